// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with a 1-entry ready/valid holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [2:0]             idx_q;
  logic [7:0]             shift_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic                   rxs;

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic pbad_q;
`endif

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      sync_q  <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // Drain; a delivery in the same cycle overrides this below.
      if (valid_q && rx_ready) valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rxs ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            pbad_q  <= rxs ^ (^shift_q);
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rxs) begin
              if (!valid_q || rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              perr_q <= pbad_q;
`endif
              // Leaving mid stop bit lets an immediately following start edge be seen.
              state_q <= StIdle;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          if (rxs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != StIdle);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; serial frames are driven by bench tasks.
module tb_uart_rx;

  localparam int unsigned Clks = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(
    .CLKS_PER_BIT(Clks),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] last_acc = 8'h00;

  // Event counters observed away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= rx_data;
    end
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(Clks);
  endtask

`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  // Leaves rx at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_b);
  endtask

  int a0, f0, o0, p0;
  logic [7:0] abort_byte;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_busy", {31'b0, rx_busy}, 32'd0);
    check("rst_data", {24'b0, rx_data}, 32'h0);
    check("rst_errs", {29'b0, frame_err, overrun, parity_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // 1: plain frame
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hAA, 1'b1);
    idle(10);
    check("t1_acc", acc_cnt - a0, 32'd1);
    check("t1_data", {24'b0, last_acc}, 32'hAA);
    check("t1_ferr", ferr_cnt - f0, 32'd0);
    check("t1_ovr", ovr_cnt - o0, 32'd0);
    check("t1_busy", {31'b0, rx_busy}, 32'd0);

    // 2: short glitch rejected
    a0 = acc_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3);
    check("t2_busy_start", {31'b0, rx_busy}, 32'd1);
    idle(20);
    check("t2_busy_idle", {31'b0, rx_busy}, 32'd0);
    check("t2_acc", acc_cnt - a0, 32'd0);
    check("t2_ferr", ferr_cnt - f0, 32'd0);

    // 3: framing error then break, then recovery
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    idle(40);
    check("t3_busy_break", {31'b0, rx_busy}, 32'd1);
    check("t3_ferr", ferr_cnt - f0, 32'd1);
    check("t3_acc_none", acc_cnt - a0, 32'd0);
    rx = 1'b1;
    idle(5);
    check("t3_busy_idle", {31'b0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("t3_acc", acc_cnt - a0, 32'd1);
    check("t3_data", {24'b0, last_acc}, 32'h3C);
    check("t3_ferr_once", ferr_cnt - f0, 32'd1);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    a0 = acc_cnt; o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    idle(4);
    send_frame(8'h22, 1'b1);
    idle(10);
    check("t4_valid", {31'b0, rx_valid}, 32'd1);
    check("t4_data", {24'b0, rx_data}, 32'h11);
    check("t4_ovr", ovr_cnt - o0, 32'd1);
    check("t4_acc_none", acc_cnt - a0, 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_hs", {31'b0, rx_valid}, 32'd1);
    @(negedge clk);
    check("t4_valid_drop", {31'b0, rx_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t4_acc", acc_cnt - a0, 32'd1);
    check("t4_acc_data", {24'b0, last_acc}, 32'h11);

    // 5: reset during data bit 4
    a0 = acc_cnt;
    abort_byte = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rx = abort_byte[4];
    idle(8);
    check("t5_busy_pre", {31'b0, rx_busy}, 32'd1);
    rst_n = 1'b0;
    idle(2);
    check("t5_rst_valid", {31'b0, rx_valid}, 32'd0);
    check("t5_rst_busy", {31'b0, rx_busy}, 32'd0);
    check("t5_rst_data", {24'b0, rx_data}, 32'h0);
    rst_n = 1'b1;
    rx = 1'b1;
    idle(40);
    check("t5_no_out", acc_cnt - a0, 32'd0);
    send_frame(8'hF0, 1'b1);
    idle(10);
    check("t5_acc", acc_cnt - a0, 32'd1);
    check("t5_data", {24'b0, last_acc}, 32'hF0);

`ifdef UART_RX_PARITY_EN
    // 6: parity error flagged, byte still delivered
    a0 = acc_cnt; p0 = perr_cnt;
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(10);
    check("t6_perr", perr_cnt - p0, 32'd1);
    check("t6_acc", acc_cnt - a0, 32'd1);
    check("t6_data", {24'b0, last_acc}, 32'h07);
    p0 = perr_cnt;
    bad_par = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(10);
    check("t6_perr_ok", perr_cnt - p0, 32'd0);
    check("t6_acc2", acc_cnt - a0, 32'd2);
`else
    p0 = 0;
    check("par_tied", perr_cnt - p0, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
